coeff_loader: RTL and testbench
===============================

# coeff_loader

Coefficient bank writer for one equalizer band filter. It accepts a stream of signed taps over a valid/ready handshake into a shadow bank, then swaps the shadow bank into the active bank only on a sample boundary, so a convolution pass never mixes two coefficient sets. The active bank drives the filter's flat `coeffs_feed` bus, and the boundary is marked by the sequencer's `phase_min` strobe.

## Interface
- `NUMBER_OF_TAPS`, 64, taps per coefficient set.
- `COEFF_BITS`, 16, width of one signed tap.
- `COUNTER_BITS`, 6, write-index width; must satisfy 2**COUNTER_BITS >= NUMBER_OF_TAPS.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-low.
- `phase_min`  in  1  sample-boundary strobe from the sequencer.
- `load_start`  in  1  begin loading a new set.
- `coeff_in`  in  COEFF_BITS  signed tap, sent in order tap 0 first.
- `coeff_valid`  in  1  `coeff_in` is valid.
- `coeff_ready`  out  1  loader accepts a tap this cycle.
- `coeffs_feed`  out  COEFF_BITS*NUMBER_OF_TAPS  active bank; tap k is at [k*COEFF_BITS +: COEFF_BITS].
- `busy`  out  1  state is not IDLE.
- `load_done`  out  1  one-cycle pulse when a new bank becomes active.
- `load_error`  out  1  one-cycle pulse when a load is aborted and restarted.

## Operation
- FSM states: IDLE, LOAD, PEND.
- **IDLE:** `coeff_ready`=0.
  - `load_start`=1 → LOAD; write index := 0.
- **LOAD:** `coeff_ready`=1.
  - A tap transfers only when `coeff_valid` and `coeff_ready` are both 1.
  - Each transfer writes shadow[idx] and increments idx.
  - The transfer at idx==NUMBER_OF_TAPS-1 moves the FSM to PEND.
- **PEND:** `coeff_ready`=0.
  - `phase_min`=1 → active bank := shadow bank, `load_done` pulses, FSM → IDLE.
- `load_start` during LOAD:
  - idx := 0 and `load_error` pulses; the FSM stays in LOAD.
  - If a transfer happens in the same cycle, it is discarded.
- `load_start` during PEND is ignored; the pending set is kept.
- Last-tap transfer in the same cycle as `phase_min`=1: the FSM enters PEND with no swap. The swap waits for the next `phase_min`.
- Taps are stored verbatim, with no saturation or rescaling.
- The active bank never changes outside the PEND→IDLE swap edge or reset.
- The shadow bank is not reset. Its contents are undefined until the first full load.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from any input to any output.
- **Reset:**
  - FSM → IDLE; idx=0.
  - `coeff_ready`=0, `busy`=0, `load_done`=0, `load_error`=0.
  - `coeffs_feed` = reset pattern (see Configuration).
- Reset asserted mid-LOAD or mid-PEND abandons the load; no `load_done` or `load_error` is produced.
- Swap latency: `coeffs_feed` shows the new set, and `load_done`=1, in the cycle after the edge that samples `phase_min`=1 in PEND.
- Minimum load time is NUMBER_OF_TAPS cycles, plus 1 cycle to enter PEND, plus the wait for `phase_min`.
- `busy` rises the cycle after `load_start` is accepted and falls together with the `load_done` pulse.

## Configuration
- Macro: `COEFF_LOADER_UNITY_RESET_EN`.
- Defined: reset sets the active bank to a unity impulse:
  - tap 0 = maximum positive value, 2**(COEFF_BITS-1)-1;
  - all other taps = 0.
  - The band therefore passes audio straight through before its first load.
- Undefined: reset sets every active tap to 0, so the band is muted until its first load.

## Structure
- Shared package `coeff_loader_pkg` holds:
  - the state enum (IDLE, LOAD, PEND);
  - the unity-tap constant function of COEFF_BITS.
- Sub-module `coeff_bank` holds:
  - the shadow array with its indexed write port;
  - the active array with its reset pattern and swap strobe;
  - the flattening of the active array onto `coeffs_feed`.
- The top level holds only the FSM, the write index and the pulse outputs.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles, then release.
  - `coeffs_feed` is all-zero, or tap0=0x7FFF with the macro defined.
  - `coeff_ready`, `busy`, `load_done` and `load_error` are all 0.
- **Basic load:** pulse `load_start`, stream taps k+1 for k=0..63 back-to-back, then pulse `phase_min` 5 cycles later.
  - `coeffs_feed` is unchanged until the swap.
  - After the swap, tap k = k+1 and `load_done` is 1 for exactly one cycle.
- **Throttled input:** toggle `coeff_valid` randomly at 50%.
  - Exactly 64 transfers are accepted, in order.
  - `coeff_ready` falls after the 64th transfer.
- **Abort and restart:** send 10 taps of 0x1111, pulse `load_start`, then send 64 taps of 0x2222 and a `phase_min`.
  - `load_error` pulses once.
  - The final bank is all 0x2222.
- **Reset during PEND:** complete a load of 0x3333 taps, then assert `rst`=0 before any `phase_min`.
  - The bank returns to the reset pattern.
  - No `load_done` pulse occurs and the FSM is in IDLE.
- **Same-cycle boundary:** make the last-tap transfer coincide with `phase_min`=1.
  - There is no swap that cycle.
  - The swap and `load_done` follow the next `phase_min`, 8 cycles later.

Source files
------------

// File: rtl/coeff_loader_pkg.sv
// coeff_loader_pkg: shared types and helpers for the coefficient loader.
//   state_e   : loader FSM states (idle, loading the shadow bank, pending swap).
//   unity_tap : largest positive signed value for a tap of the given width,
//               used as the pass-through impulse when the unity reset is built in.
package coeff_loader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StPend
  } state_e;

  function automatic int unsigned unity_tap(input int unsigned bits);
    return (32'd1 << (bits - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/coeff_bank.sv
// coeff_bank: shadow and active coefficient storage for one band filter.
//   clk_i      : system clock
//   rst_ni     : synchronous active-low reset (active bank only)
//   wr_en_i    : write wr_data_i into shadow[wr_idx_i]
//   wr_idx_i   : shadow write index
//   wr_data_i  : signed tap, stored verbatim
//   swap_i     : copy the whole shadow bank into the active bank
//   feed_o     : active bank flattened, tap k at [k*COEFF_BITS +: COEFF_BITS]
// Build option COEFF_LOADER_UNITY_RESET_EN: when defined, reset loads a unity
// impulse (tap 0 at full scale, rest 0); otherwise every active tap resets to 0.
module coeff_bank
  import coeff_loader_pkg::*;
#(
  parameter int unsigned NUMBER_OF_TAPS = 64,
  parameter int unsigned COEFF_BITS     = 16,
  parameter int unsigned COUNTER_BITS   = 6
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 wr_en_i,
  input  logic [COUNTER_BITS-1:0]              wr_idx_i,
  input  logic [COEFF_BITS-1:0]                wr_data_i,
  input  logic                                 swap_i,
  output logic [COEFF_BITS*NUMBER_OF_TAPS-1:0] feed_o
);

  logic [COEFF_BITS-1:0] shadow_q [NUMBER_OF_TAPS];
  logic [COEFF_BITS-1:0] active_q [NUMBER_OF_TAPS];

  // Shadow bank is deliberately not reset; it only matters after a full load.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      shadow_q[wr_idx_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUMBER_OF_TAPS; k++) begin
        active_q[k] <= '0;
      end
`ifdef COEFF_LOADER_UNITY_RESET_EN
      active_q[0] <= COEFF_BITS'(unity_tap(COEFF_BITS));
`endif
    end else if (swap_i) begin
      active_q <= shadow_q;
    end
  end

  always_comb begin
    feed_o = '0;
    for (int k = 0; k < NUMBER_OF_TAPS; k++) begin
      feed_o[k*COEFF_BITS +: COEFF_BITS] = active_q[k];
    end
  end

endmodule

// File: rtl/coeff_loader.sv
// coeff_loader: streams signed taps into a shadow bank and swaps them into the
// active bank only on a sample boundary (phase_min), so a convolution pass never
// mixes two coefficient sets.
//   clk         : system clock
//   rst         : synchronous active-low reset
//   phase_min   : sample-boundary strobe
//   load_start  : begin (or restart) loading a coefficient set
//   coeff_in    : signed tap, tap 0 first
//   coeff_valid : coeff_in is valid
//   coeff_ready : a tap is accepted this cycle
//   coeffs_feed : active bank, tap k at [k*COEFF_BITS +: COEFF_BITS]
//   busy        : loader not idle
//   load_done   : one-cycle pulse when a new bank becomes active
//   load_error  : one-cycle pulse when a load is aborted and restarted
// Build option COEFF_LOADER_UNITY_RESET_EN selects the unity-impulse reset
// pattern of the active bank (see coeff_bank).
module coeff_loader
  import coeff_loader_pkg::*;
#(
  parameter int unsigned NUMBER_OF_TAPS = 64,
  parameter int unsigned COEFF_BITS     = 16,
  parameter int unsigned COUNTER_BITS   = 6
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 phase_min,
  input  logic                                 load_start,
  input  logic [COEFF_BITS-1:0]                coeff_in,
  input  logic                                 coeff_valid,
  output logic                                 coeff_ready,
  output logic [COEFF_BITS*NUMBER_OF_TAPS-1:0] coeffs_feed,
  output logic                                 busy,
  output logic                                 load_done,
  output logic                                 load_error
);

  localparam logic [COUNTER_BITS-1:0] LastIdx = COUNTER_BITS'(NUMBER_OF_TAPS - 1);

  state_e                  state_q;
  logic [COUNTER_BITS-1:0] idx_q;
  logic                    coeff_ready_q;
  logic                    busy_q;
  logic                    load_done_q;
  logic                    load_error_q;

  logic wr_en;
  logic swap;

  // A tap landing in the same cycle as a restart is dropped so the new set
  // starts cleanly at index 0.
  always_comb begin
    wr_en = (state_q == StLoad) && coeff_valid && !load_start;
    swap  = (state_q == StPend) && phase_min;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      coeff_ready_q <= 1'b0;
      busy_q        <= 1'b0;
      load_done_q   <= 1'b0;
      load_error_q  <= 1'b0;
    end else begin
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (load_start) begin
            state_q       <= StLoad;
            idx_q         <= '0;
            coeff_ready_q <= 1'b1;
            busy_q        <= 1'b1;
          end
        end
        StLoad: begin
          if (load_start) begin
            idx_q        <= '0;
            load_error_q <= 1'b1;
          end else if (coeff_valid) begin
            idx_q <= idx_q + COUNTER_BITS'(1);
            // phase_min is not looked at here: a boundary coinciding with the
            // last tap must wait for the next one.
            if (idx_q == LastIdx) begin
              state_q       <= StPend;
              coeff_ready_q <= 1'b0;
            end
          end
        end
        StPend: begin
          if (phase_min) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            load_done_q <= 1'b1;
          end
        end
        default: begin
          state_q       <= StIdle;
          coeff_ready_q <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign coeff_ready = coeff_ready_q;
  assign busy        = busy_q;
  assign load_done   = load_done_q;
  assign load_error  = load_error_q;

  coeff_bank #(
    .NUMBER_OF_TAPS (NUMBER_OF_TAPS),
    .COEFF_BITS     (COEFF_BITS),
    .COUNTER_BITS   (COUNTER_BITS)
  ) u_bank (
    .clk_i     (clk),
    .rst_ni    (rst),
    .wr_en_i   (wr_en),
    .wr_idx_i  (idx_q),
    .wr_data_i (coeff_in),
    .swap_i    (swap),
    .feed_o    (coeffs_feed)
  );

endmodule

// File: tb/tb_coeff_loader.sv
// Self-checking bench for coeff_loader: scenario tasks with a bench-side model
// of the expected active bank, updated only when a swap is expected.
module tb_coeff_loader;

  localparam int N  = 64;
  localparam int W  = 16;
  localparam int CB = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           phase_min = 1'b0;
  logic           load_start = 1'b0;
  logic [W-1:0]   coeff_in = '0;
  logic           coeff_valid = 1'b0;
  logic           coeff_ready;
  logic [W*N-1:0] coeffs_feed;
  logic           busy;
  logic           load_done;
  logic           load_error;

  int total  = 0;
  int passed = 0;
  int err_cnt  = 0;
  int done_cnt = 0;

  logic [W-1:0] src      [N];
  logic [W-1:0] exp_bank [N];

  coeff_loader #(
    .NUMBER_OF_TAPS (N),
    .COEFF_BITS     (W),
    .COUNTER_BITS   (CB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .phase_min   (phase_min),
    .load_start  (load_start),
    .coeff_in    (coeff_in),
    .coeff_valid (coeff_valid),
    .coeff_ready (coeff_ready),
    .coeffs_feed (coeffs_feed),
    .busy        (busy),
    .load_done   (load_done),
    .load_error  (load_error)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the inactive edge.
  always @(negedge clk) begin
    if (load_error) err_cnt++;
    if (load_done) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] tap(input int k);
    return coeffs_feed[k*W +: W];
  endfunction

  function automatic void set_reset_pattern();
    for (int k = 0; k < N; k++) exp_bank[k] = '0;
`ifdef COEFF_LOADER_UNITY_RESET_EN
    exp_bank[0] = 16'h7FFF;
`endif
  endfunction

  function automatic void take_src();
    for (int k = 0; k < N; k++) exp_bank[k] = src[k];
  endfunction

  task automatic pulse_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic pulse_phase();
    phase_min = 1'b1;
    step();
    phase_min = 1'b0;
  endtask

  // Sends src[0..N-1]; every valid cycle is a transfer while loading.
  task automatic stream(input bit throttle, input bit phase_on_last);
    int sent = 0;
    int cyc  = 0;
    while (sent < N && cyc < 2000) begin
      coeff_valid = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      coeff_in    = src[sent];
      phase_min   = phase_on_last && coeff_valid && (sent == N - 1);
      step();
      cyc++;
      if (coeff_valid) sent++;
    end
    coeff_valid = 1'b0;
    phase_min   = 1'b0;
    total++;
    if (sent !== N) $display("FAIL stream_timeout sent=%0d required=%0d", sent, N);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    set_reset_pattern();
    for (int k = 0; k < N; k++) begin
      total++;
      if (tap(k) !== exp_bank[k])
        $display("FAIL reset_tap%0d got=%h required=%h", k, tap(k), exp_bank[k]);
      else passed++;
    end
    total++;
    if ({coeff_ready, busy, load_done, load_error} !== 4'b0000)
      $display("FAIL reset_outputs got=%b required=0000",
               {coeff_ready, busy, load_done, load_error});
    else passed++;
  endtask

  task automatic test_basic_load();
    for (int k = 0; k < N; k++) src[k] = W'(k + 1);
    done_cnt = 0;
    pulse_load();
    total++;
    if ({busy, coeff_ready} !== 2'b11)
      $display("FAIL basic_busy_ready got=%b required=11", {busy, coeff_ready});
    else passed++;
    stream(1'b0, 1'b0);
    total++;
    if ({busy, coeff_ready} !== 2'b10)
      $display("FAIL basic_pend got=%b required=10", {busy, coeff_ready});
    else passed++;
    repeat (4) begin
      step();
      total++;
      if (tap(1) !== exp_bank[1] || tap(N - 1) !== exp_bank[N - 1] || load_done !== 1'b0)
        $display("FAIL basic_early_swap tap1=%h done=%b required=%h/0",
                 tap(1), load_done, exp_bank[1]);
      else passed++;
    end
    pulse_phase();
    take_src();
    total++;
    if ({load_done, busy} !== 2'b10)
      $display("FAIL basic_done got=%b required=10", {load_done, busy});
    else passed++;
    for (int k = 0; k < N; k++) begin
      total++;
      if (tap(k) !== exp_bank[k])
        $display("FAIL basic_tap%0d got=%h required=%h", k, tap(k), exp_bank[k]);
      else passed++;
    end
    step();
    step();
    total++;
    if (done_cnt !== 1) $display("FAIL basic_done_width got=%0d required=1", done_cnt);
    else passed++;
  endtask

  task automatic test_throttled();
    int sent = 0;
    int cyc  = 0;
    for (int k = 0; k < N; k++) src[k] = W'($urandom);
    pulse_load();
    while (sent < N && cyc < 2000) begin
      total++;
      if (coeff_ready !== 1'b1)
        $display("FAIL thr_ready sent=%0d got=%b required=1", sent, coeff_ready);
      else passed++;
      coeff_valid = 1'($urandom_range(0, 1));
      coeff_in    = coeff_valid ? src[sent] : W'($urandom);
      step();
      cyc++;
      if (coeff_valid) sent++;
    end
    coeff_valid = 1'b0;
    total++;
    if (sent !== N || coeff_ready !== 1'b0)
      $display("FAIL thr_end sent=%0d ready=%b required=%0d/0", sent, coeff_ready, N);
    else passed++;
    // Extra valid taps while pending must be ignored.
    coeff_valid = 1'b1;
    coeff_in    = 16'hDEAD;
    step();
    coeff_valid = 1'b0;
    pulse_phase();
    take_src();
    for (int k = 0; k < N; k++) begin
      total++;
      if (tap(k) !== exp_bank[k])
        $display("FAIL thr_tap%0d got=%h required=%h", k, tap(k), exp_bank[k]);
      else passed++;
    end
  endtask

  task automatic test_abort_restart();
    err_cnt = 0;
    pulse_load();
    coeff_valid = 1'b1;
    coeff_in    = 16'h1111;
    repeat (10) step();
    // Restart with a coincident tap that must be discarded.
    load_start = 1'b1;
    step();
    load_start  = 1'b0;
    coeff_valid = 1'b0;
    total++;
    if ({load_error, busy, coeff_ready} !== 3'b111)
      $display("FAIL abort_pulse got=%b required=111", {load_error, busy, coeff_ready});
    else passed++;
    for (int k = 0; k < N; k++) src[k] = 16'h2222;
    stream(1'b0, 1'b0);
    pulse_phase();
    take_src();
    step();
    total++;
    if (err_cnt !== 1) $display("FAIL abort_err_count got=%0d required=1", err_cnt);
    else passed++;
    for (int k = 0; k < N; k++) begin
      total++;
      if (tap(k) !== exp_bank[k])
        $display("FAIL abort_tap%0d got=%h required=%h", k, tap(k), exp_bank[k]);
      else passed++;
    end
  endtask

  task automatic test_reset_during_pend();
    for (int k = 0; k < N; k++) src[k] = 16'h3333;
    pulse_load();
    stream(1'b0, 1'b0);
    done_cnt = 0;
    err_cnt  = 0;
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    set_reset_pattern();
    total++;
    if ({coeff_ready, busy, load_done, load_error} !== 4'b0000 || done_cnt !== 0 || err_cnt !== 0)
      $display("FAIL rstpend_outputs got=%b done=%0d err=%0d required=0000/0/0",
               {coeff_ready, busy, load_done, load_error}, done_cnt, err_cnt);
    else passed++;
    // A boundary now must not resurrect the abandoned set.
    pulse_phase();
    step();
    total++;
    if (load_done !== 1'b0 || done_cnt !== 0)
      $display("FAIL rstpend_no_done got=%b/%0d required=0/0", load_done, done_cnt);
    else passed++;
    for (int k = 0; k < N; k++) begin
      total++;
      if (tap(k) !== exp_bank[k])
        $display("FAIL rstpend_tap%0d got=%h required=%h", k, tap(k), exp_bank[k]);
      else passed++;
    end
  endtask

  task automatic test_same_cycle_boundary();
    for (int k = 0; k < N; k++) src[k] = W'($urandom);
    done_cnt = 0;
    pulse_load();
    stream(1'b0, 1'b1);
    total++;
    if ({load_done, busy, coeff_ready} !== 3'b010)
      $display("FAIL same_no_swap got=%b required=010", {load_done, busy, coeff_ready});
    else passed++;
    for (int i = 0; i < 7; i++) begin
      total++;
      if (tap(0) !== exp_bank[0] || tap(N - 1) !== exp_bank[N - 1] || load_done !== 1'b0)
        $display("FAIL same_wait%0d tap0=%h done=%b required=%h/0",
                 i, tap(0), load_done, exp_bank[0]);
      else passed++;
      step();
    end
    pulse_phase();
    take_src();
    total++;
    if ({load_done, busy} !== 2'b10)
      $display("FAIL same_done got=%b required=10", {load_done, busy});
    else passed++;
    for (int k = 0; k < N; k++) begin
      total++;
      if (tap(k) !== exp_bank[k])
        $display("FAIL same_tap%0d got=%h required=%h", k, tap(k), exp_bank[k]);
      else passed++;
    end
    step();
    total++;
    if (done_cnt !== 1) $display("FAIL same_done_count got=%0d required=1", done_cnt);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_throttled();
    test_abort_restart();
    test_reset_during_pend();
    test_same_cycle_boundary();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
